// File: rtl/add_sched_if.sv
// Operand/result handshake bundle between the requesters, the consumer and add_sched.
// Master drives requests and accepts results; slave is the scheduler.
interface add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_carry, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_carry, res_id
  );
endinterface

// File: rtl/add_sched.sv
// Two-requester round-robin adder: accepts one operand pair at a time, adds it,
// and holds the registered sum until the consumer takes it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a granted requester; the only state with a ready
// EXEC  | latched operands are summed into the result registers
// DONE  | result presented (res_valid=1) until res_ready accepts it
module add_sched #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  add_sched_if.slave  bus,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;

  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic [WIDTH:0]   sum_full;

  // With both requesters asking, whoever was not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last;
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign accept         = rst_n && ena && (state == IDLE) && grant_vld;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_carry <= 1'b0;
      bus.res_id    <= 1'b0;
      op_count      <= 8'd0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_a  <= grant_id ? bus.req1_a : bus.req0_a;
            op_b  <= grant_id ? bus.req1_b : bus.req0_b;
            op_id <= grant_id;
            last  <= grant_id;
            state <= EXEC;
          end
        end
        EXEC: begin
          {bus.res_carry, bus.res_sum} <= sum_full;
          bus.res_id    <= op_id;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            op_count      <= op_count + 8'd1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.res_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// Scoreboard bench for add_sched: stimulus queues hand-computed results,
// a negedge monitor compares every accepted result in order.
module tb_add_sched;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       busy;
  logic [7:0] op_count;

  add_sched_if #(.WIDTH(8)) bus ();

  add_sched #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  typedef struct packed {
    logic       id;
    logic [8:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: a result transfer happens at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if (bus.res_valid && bus.res_ready && ena) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_sum",   {24'd0, bus.res_sum}, {24'd0, e.res[7:0]});
          chk("res_carry", {31'd0, bus.res_carry}, {31'd0, e.res[8]});
          chk("res_id",    {31'd0, bus.res_id}, {31'd0, e.id});
        end
      end
    end
  end

  // Queue the expected result, raise valid, and return just after the transfer edge.
  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] want);
    bit seen;
    seen = 1'b0;
    exp_q.push_back({id, want});
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("req_accept", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] want);
    issue(id, a, b, want);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    ena = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.res_ready = 1'b1;
    #12;
    chk("rst_ready0",    {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_op_count",  {24'd0, op_count}, 32'd0);
    chk("rst_res_sum",   {24'd0, bus.res_sum}, 32'd0);
    bus.req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single op with latency check.
    issue(1'b0, 8'h12, 8'h34, 9'h046);
    chk("lat_exec_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("lat_exec_busy",  {31'd0, busy}, 32'd1);
    tick();
    chk("lat_done_valid", {31'd0, bus.res_valid}, 32'd1);
    tick();
    chk("single_op_count", {24'd0, op_count}, 32'd1);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Overflow cases.
    run_op(1'b1, 8'hFF, 8'h01, 9'h100);
    run_op(1'b0, 8'h80, 8'h80, 9'h100);
    chk("ovf_op_count", {24'd0, op_count}, 32'd3);

    // Contention straight out of reset: grants 0,1,0,1.
    pulse_reset();
    chk("cont_rst_count", {24'd0, op_count}, 32'd0);
    bus.req0_a = 8'h01; bus.req0_b = 8'h02;
    bus.req1_a = 8'h10; bus.req1_b = 8'h20;
    exp_q.push_back({1'b0, 9'h003});
    exp_q.push_back({1'b1, 9'h030});
    exp_q.push_back({1'b0, 9'h003});
    exp_q.push_back({1'b1, 9'h030});
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (op_count == 8'd4) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("cont_done", {31'd0, ok}, 32'd1);
    chk("cont_queue_empty", exp_q.size(), 32'd0);
    tick();
    tick();
    tick();
    chk("cont_op_count", {24'd0, op_count}, 32'd4);

    // Backpressure: result must stay frozen for five cycles.
    bus.res_ready = 1'b0;
    issue(1'b0, 8'h55, 8'h0A, 9'h05F);
    tick();
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",  {31'd0, bus.res_valid}, 32'd1);
      chk("bp_sum",    {24'd0, bus.res_sum}, 32'h5F);
      chk("bp_id",     {31'd0, bus.res_id}, 32'd0);
      chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("bp_count",  {24'd0, op_count}, 32'd4);
    end
    bus.req1_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    chk("bp_release_count", {24'd0, op_count}, 32'd5);

    // ena=0 for three cycles in EXEC, then for two in DONE.
    issue(1'b1, 8'h3C, 8'h4D, 9'h089);
    ena = 1'b0;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ena_hold_busy",  {31'd0, busy}, 32'd1);
      chk("ena_hold_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("ena_hold_ready", {31'd0, bus.req0_ready}, 32'd0);
    end
    bus.req0_valid = 1'b0;
    ena = 1'b1;
    ena = 1'b0;
    ena = 1'b1;
    tick();
    chk("ena_resume_valid", {31'd0, bus.res_valid}, 32'd1);
    ena = 1'b0;
    tick();
    tick();
    chk("ena_done_count", {24'd0, op_count}, 32'd5);
    chk("ena_done_valid", {31'd0, bus.res_valid}, 32'd1);
    ena = 1'b1;
    tick();
    chk("ena_final_count", {24'd0, op_count}, 32'd6);

    // Reset while a result is pending in DONE.
    bus.res_ready = 1'b0;
    issue(1'b1, 8'h11, 8'h22, 9'h033);
    tick();
    chk("rd_pending", {31'd0, bus.res_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rd_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rd_count", {24'd0, op_count}, 32'd0);
    chk("rd_busy",  {31'd0, busy}, 32'd0);
    chk("rd_sum",   {24'd0, bus.res_sum}, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;

    // First tie after reset goes to requester 0.
    bus.req0_a = 8'h07; bus.req0_b = 8'h09;
    bus.req1_a = 8'hA0; bus.req1_b = 8'h0B;
    exp_q.push_back({1'b0, 9'h010});
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("tie_count", {24'd0, op_count}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
